// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: button edge detection, run/pause/set modes, centisecond prescaler, counter strobes.
// Latency: every output is registered; the response to an event seen in cycle N appears in cycle N+1.
// Backpressure: none; button events are edge-triggered and at most one is acted on per cycle.
module stopwatch_controller #(
   parameter int unsigned TICK_DIV = 500000
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       btn_start,
   input  logic       btn_reset,
   input  logic       btn_set,
   input  logic       btn_lap,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic       rco_cs,
   input  logic       rco_s,
   output logic       cnt_clear,
   output logic       cnt_mode,
   output logic [2:0] cnt_count,
   output logic [2:0] cnt_inc,
   output logic [2:0] cnt_dec,
   output logic [1:0] sel,
   output logic       display_hold,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_SET   = 2'b11
   } state_t;

   // Last prescaler value before wrap; TICK_DIV <= 2^20 keeps this inside 20 bits.
   localparam logic [19:0] PRESC_LAST = 20'(TICK_DIV - 1);

   // Button bit order doubles as priority order: bit 0 (reset) is the highest.
   logic [5:0]  w_btn;
   logic [5:0]  w_rise;
   logic [5:0]  w_evt;
   logic        w_ev_reset;
   logic        w_ev_start;
   logic        w_ev_set;
   logic        w_ev_lap;
   logic        w_ev_inc;
   logic        w_ev_dec;
   logic        w_tick;
   logic [2:0]  w_sel_onehot;
   logic [1:0]  w_sel_next;

   logic [5:0]  r_btn_q;
   logic        r_armed;
   state_t      r_state;
   logic [19:0] r_presc;
   logic [1:0]  r_sel;
   logic        r_hold;
   logic        r_mode;
   logic        r_clear;
   logic [2:0]  r_count;
   logic [2:0]  r_inc;
   logic [2:0]  r_dec;

   assign w_btn = {btn_dec, btn_inc, btn_lap, btn_set, btn_start, btn_reset};

   // r_armed stays low for the first edge after reset release so a button
   // that was already held while clear was asserted cannot fire an event.
   assign w_rise = r_armed ? (w_btn & ~r_btn_q) : 6'b000000;

   // Keep only the highest-priority rising edge; the rest are discarded.
   always_comb begin
      w_evt = 6'b000000;
      if (w_rise[0])      w_evt = 6'b000001;
      else if (w_rise[1]) w_evt = 6'b000010;
      else if (w_rise[2]) w_evt = 6'b000100;
      else if (w_rise[3]) w_evt = 6'b001000;
      else if (w_rise[4]) w_evt = 6'b010000;
      else if (w_rise[5]) w_evt = 6'b100000;
   end

   assign w_ev_reset = w_evt[0];
   assign w_ev_start = w_evt[1];
   assign w_ev_set   = w_evt[2];
   assign w_ev_lap   = w_evt[3];
   assign w_ev_inc   = w_evt[4];
   assign w_ev_dec   = w_evt[5];

   // A tick is the RUN cycle in which the prescaler wraps.
   assign w_tick       = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
   assign w_sel_onehot = 3'b001 << r_sel;
   assign w_sel_next   = (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;

   // Button history and the post-reset arming flag.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_btn_q <= 6'b000000;
         r_armed <= 1'b0;
      end else begin
         r_btn_q <= w_btn;
         r_armed <= 1'b1;
      end
   end

   // Prescaler advances on every RUN cycle, including the cycle that leaves
   // RUN: a tick landing on that cycle is consumed without a count pulse.
   // Starting from IDLE restarts it from zero; resuming from PAUSE keeps it.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_presc <= 20'd0;
      end else if (r_state == ST_IDLE && w_ev_start) begin
         r_presc <= 20'd0;
      end else if (r_state == ST_RUN) begin
         r_presc <= w_tick ? 20'd0 : r_presc + 20'd1;
      end
   end

   // Main control FSM with registered pulse and level outputs.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_state <= ST_IDLE;
         r_sel   <= 2'd0;
         r_hold  <= 1'b0;
         r_mode  <= 1'b0;
         r_clear <= 1'b0;
         r_count <= 3'b000;
         r_inc   <= 3'b000;
         r_dec   <= 3'b000;
      end else begin
         // Pulses last exactly one cycle unless re-armed below.
         r_clear <= 1'b0;
         r_count <= 3'b000;
         r_inc   <= 3'b000;
         r_dec   <= 3'b000;
         case (r_state)
            ST_IDLE: begin
               if (w_ev_start) begin
                  r_state <= ST_RUN;
               end else if (w_ev_set) begin
                  r_state <= ST_SET;
                  r_sel   <= 2'd0;
                  r_hold  <= 1'b0;
                  r_mode  <= 1'b1;
               end else if (w_ev_reset) begin
                  r_clear <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_ev_start) begin
                  // Leaving RUN: any coincident tick is dropped.
                  r_state <= ST_PAUSE;
               end else begin
                  if (w_ev_lap) begin
                     r_hold <= ~r_hold;
                  end
                  // Seconds and minutes enables ride on the centisecond tick.
                  r_count <= {w_tick & rco_cs & rco_s, w_tick & rco_cs, w_tick};
               end
            end
            ST_PAUSE: begin
               if (w_ev_reset) begin
                  r_state <= ST_IDLE;
                  r_clear <= 1'b1;
                  r_hold  <= 1'b0;
               end else if (w_ev_start) begin
                  r_state <= ST_RUN;
               end else if (w_ev_set) begin
                  r_state <= ST_SET;
                  r_sel   <= 2'd0;
                  r_hold  <= 1'b0;
                  r_mode  <= 1'b1;
               end
            end
            ST_SET: begin
               if (w_ev_set) begin
                  r_state <= ST_IDLE;
                  r_mode  <= 1'b0;
               end else if (w_ev_lap) begin
                  r_sel <= w_sel_next;
               end else if (w_ev_inc) begin
                  r_inc <= w_sel_onehot;
               end else if (w_ev_dec) begin
                  r_dec <= w_sel_onehot;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_mode  <= 1'b0;
            end
         endcase
      end
   end

   assign cnt_clear    = r_clear;
   assign cnt_mode     = r_mode;
   assign cnt_count    = r_count;
   assign cnt_inc      = r_inc;
   assign cnt_dec      = r_dec;
   assign sel          = r_sel;
   assign display_hold = r_hold;
   assign fsm_state    = r_state;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller with TICK_DIV=4.
// Directed scenarios plus randomized button traffic against a behavioural model.
// Model tracks mode, elapsed RUN cycles and selected field as plain integers.
module tb_stopwatch_controller;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic [5:0] b = 6'b000000;   // 0 reset, 1 start, 2 set, 3 lap, 4 inc, 5 dec
   logic       rco_cs = 1'b0;
   logic       rco_s = 1'b0;

   logic       cnt_clear;
   logic       cnt_mode;
   logic [2:0] cnt_count;
   logic [2:0] cnt_inc;
   logic [2:0] cnt_dec;
   logic [1:0] sel;
   logic       display_hold;
   logic [1:0] fsm_state;

   int total = 0;
   int bad = 0;

   // Behavioural model: mode 0 idle, 1 run, 2 pause, 3 set.
   int         m_state;
   int         m_run;       // RUN cycles elapsed since the last start from IDLE
   int         m_sel;
   logic       m_hold;
   logic       m_clear;
   logic [2:0] m_cnt;
   logic [2:0] m_inc;
   logic [2:0] m_dec;
   logic [5:0] m_prev;
   logic       m_armed;

   stopwatch_controller #(.TICK_DIV(TD)) dut (
      .clk(clk), .clear(clear),
      .btn_start(b[1]), .btn_reset(b[0]), .btn_set(b[2]),
      .btn_lap(b[3]), .btn_inc(b[4]), .btn_dec(b[5]),
      .rco_cs(rco_cs), .rco_s(rco_s),
      .cnt_clear(cnt_clear), .cnt_mode(cnt_mode), .cnt_count(cnt_count),
      .cnt_inc(cnt_inc), .cnt_dec(cnt_dec), .sel(sel),
      .display_hold(display_hold), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] dut_vec();
      return {cnt_clear, cnt_mode, cnt_count, cnt_inc, cnt_dec, sel, display_hold, fsm_state};
   endfunction

   function automatic logic [15:0] mdl_vec();
      return {m_clear, (m_state == 3), m_cnt, m_inc, m_dec, 2'(m_sel), m_hold, 2'(m_state)};
   endfunction

   task automatic model_reset();
      m_state = 0; m_run = 0; m_sel = 0; m_hold = 1'b0;
      m_clear = 1'b0; m_cnt = 3'b000; m_inc = 3'b000; m_dec = 3'b000;
      m_prev = 6'b000000; m_armed = 1'b0;
   endtask

   task automatic enter_set();
      m_state = 3; m_sel = 0; m_hold = 1'b0;
   endtask

   // One clock edge of the model, driven by the inputs present at that edge.
   task automatic model_step();
      logic [5:0] ev;
      int         p;
      logic       tk;
      if (clear) begin
         model_reset();
         return;
      end
      ev = m_armed ? (b & ~m_prev) : 6'b000000;
      m_prev = b;
      m_armed = 1'b1;
      p = -1;
      for (int i = 5; i >= 0; i--) if (ev[i]) p = i;
      tk = (m_state == 1) && ((m_run % TD) == TD - 1);
      if (m_state == 1) m_run++;
      m_clear = 1'b0; m_cnt = 3'b000; m_inc = 3'b000; m_dec = 3'b000;
      case (m_state)
         0: begin
            if (p == 1) begin m_state = 1; m_run = 0; end
            else if (p == 2) enter_set();
            else if (p == 0) m_clear = 1'b1;
         end
         1: begin
            if (p == 1) m_state = 2;
            else begin
               if (p == 3) m_hold = ~m_hold;
               if (tk) m_cnt = {rco_cs & rco_s, rco_cs, 1'b1};
            end
         end
         2: begin
            if (p == 0) begin m_state = 0; m_clear = 1'b1; m_hold = 1'b0; end
            else if (p == 1) m_state = 1;
            else if (p == 2) enter_set();
         end
         default: begin
            if (p == 2) m_state = 0;
            else if (p == 3) m_sel = (m_sel + 1) % 3;
            else if (p == 4) m_inc = 3'b001 << m_sel;
            else if (p == 5) m_dec = 3'b001 << m_sel;
         end
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic press(input int i);
      b[i] = 1'b1;
      step();
   endtask

   task automatic release_btn(input int i);
      b[i] = 1'b0;
      step();
   endtask

   task automatic test_reset();
      model_reset();
      #2;
      total++;
      if (dut_vec() !== 16'h0000) begin
         bad++; $display("FAIL reset_outputs got=%h want=%h", dut_vec(), 16'h0000);
      end
      step(); step();
      clear = 1'b0;
      step();
      total++;
      if (dut_vec() !== mdl_vec()) begin
         bad++; $display("FAIL reset_release got=%h want=%h", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_run_ticks();
      press(1);
      total++;
      if (fsm_state !== 2'b01) begin
         bad++; $display("FAIL start_to_run got=%b want=01", fsm_state);
      end
      release_btn(1);
      for (int k = 2; k <= 17; k++) begin
         step();
         total++;
         if (cnt_count !== ((k % TD == 0) ? 3'b001 : 3'b000)) begin
            bad++; $display("FAIL tick_cadence k=%0d got=%b want=%b", k, cnt_count,
                            (k % TD == 0) ? 3'b001 : 3'b000);
         end
      end
      total++;
      if (dut_vec() !== mdl_vec()) begin
         bad++; $display("FAIL run_model got=%h want=%h", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_carry();
      logic [2:0] seen;
      rco_cs = 1'b1;
      seen = 3'b000;
      for (int k = 0; k < 8 && seen == 3'b000; k++) begin
         step();
         seen = cnt_count;
      end
      total++;
      if (seen !== 3'b011) begin
         bad++; $display("FAIL carry_sec got=%b want=011", seen);
      end
      rco_s = 1'b1;
      seen = 3'b000;
      for (int k = 0; k < 8 && seen == 3'b000; k++) begin
         step();
         seen = cnt_count;
      end
      total++;
      if (seen !== 3'b111) begin
         bad++; $display("FAIL carry_min got=%b want=111", seen);
      end
      rco_cs = 1'b0; rco_s = 1'b0;
      step();
      total++;
      if (dut_vec() !== mdl_vec()) begin
         bad++; $display("FAIL carry_model got=%h want=%h", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_pause_reset();
      int pulses;
      press(3);
      total++;
      if (display_hold !== 1'b1) begin
         bad++; $display("FAIL lap_hold got=%b want=1", display_hold);
      end
      release_btn(3);
      press(1);
      total++;
      if (fsm_state !== 2'b10) begin
         bad++; $display("FAIL run_to_pause got=%b want=10", fsm_state);
      end
      release_btn(1);
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (cnt_count !== 3'b000) pulses++;
      end
      total++;
      if (pulses !== 0 || display_hold !== 1'b1) begin
         bad++; $display("FAIL pause_quiet got pulses=%0d hold=%b want pulses=0 hold=1", pulses, display_hold);
      end
      press(0);
      total++;
      if ({cnt_clear, fsm_state, display_hold} !== 4'b1000) begin
         bad++; $display("FAIL pause_reset got=%b want=1000", {cnt_clear, fsm_state, display_hold});
      end
      release_btn(0);
      total++;
      if (cnt_clear !== 1'b0) begin
         bad++; $display("FAIL clear_one_cycle got=%b want=0", cnt_clear);
      end
   endtask

   task automatic test_set_sel();
      press(2);
      total++;
      if ({fsm_state, cnt_mode} !== 3'b111) begin
         bad++; $display("FAIL enter_set got=%b want=111", {fsm_state, cnt_mode});
      end
      release_btn(2);
      press(3); release_btn(3);
      press(3); release_btn(3);
      press(4);
      total++;
      if ({sel, cnt_mode, cnt_inc} !== 6'b10_1_100) begin
         bad++; $display("FAIL set_inc got=%b want=101100", {sel, cnt_mode, cnt_inc});
      end
      release_btn(4);
      total++;
      if (cnt_inc !== 3'b000) begin
         bad++; $display("FAIL inc_one_cycle got=%b want=000", cnt_inc);
      end
      press(3);
      release_btn(3);
      press(5);
      total++;
      if ({sel, cnt_dec} !== 5'b00_001) begin
         bad++; $display("FAIL sel_wrap_dec got=%b want=00001", {sel, cnt_dec});
      end
      release_btn(5);
      press(2);
      total++;
      if ({fsm_state, cnt_mode} !== 3'b000) begin
         bad++; $display("FAIL exit_set got=%b want=000", {fsm_state, cnt_mode});
      end
      release_btn(2);
   endtask

   task automatic test_simultaneous();
      press(1); release_btn(1);
      press(1); release_btn(1);
      total++;
      if (fsm_state !== 2'b10) begin
         bad++; $display("FAIL reach_pause got=%b want=10", fsm_state);
      end
      b[0] = 1'b1; b[1] = 1'b1;
      step();
      total++;
      if ({cnt_clear, fsm_state} !== 3'b100) begin
         bad++; $display("FAIL reset_beats_start got=%b want=100", {cnt_clear, fsm_state});
      end
      step(); step();
      total++;
      if (dut_vec() !== mdl_vec() || fsm_state !== 2'b00) begin
         bad++; $display("FAIL held_no_run got=%h want=%h", dut_vec(), mdl_vec());
      end
      b[0] = 1'b0; b[1] = 1'b0;
      step();
   endtask

   task automatic test_held_and_clear();
      int wrong;
      press(1);
      wrong = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (fsm_state !== 2'b01) wrong++;
      end
      total++;
      if (wrong !== 0) begin
         bad++; $display("FAIL held_start_repeat got wrong=%0d want=0", wrong);
      end
      #2;
      clear = 1'b1;
      #1;
      total++;
      if (dut_vec() !== 16'h0000) begin
         bad++; $display("FAIL async_clear got=%h want=%h", dut_vec(), 16'h0000);
      end
      step(); step();
      clear = 1'b0;
      step(); step(); step();
      total++;
      if (dut_vec() !== mdl_vec() || fsm_state !== 2'b00) begin
         bad++; $display("FAIL held_through_clear got=%h want=%h", dut_vec(), mdl_vec());
      end
      release_btn(1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 2500; k++) begin
         if ($urandom_range(3) == 0) b[$urandom_range(5)] ^= 1'b1;
         rco_cs = 1'($urandom_range(1));
         rco_s  = 1'($urandom_range(1));
         if (k % 700 == 350) begin
            #2;
            clear = 1'b1;
            step();
            clear = 1'b0;
         end else begin
            step();
         end
         total++;
         if (dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL random k=%0d got=%h want=%h", k, dut_vec(), mdl_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_run_ticks();
      test_carry();
      test_pause_reset();
      test_set_sel();
      test_simultaneous();
      test_held_and_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
